// File: rtl/relu_stream_bridge_pkg.sv
// Shared types and helpers for the relu_stream_bridge activation/serializer block.
package relu_stream_bridge_pkg;

  typedef enum logic [1:0] {
    ACT_IDENTITY = 2'd0,
    ACT_RELU     = 2'd1,
    ACT_LEAKY    = 2'd2
  } act_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_e;

  function automatic int beats(input int num_nodes, input int lanes);
    return num_nodes / lanes;
  endfunction

  // A single-beat frame still needs a one-bit index port.
  function automatic int idx_width(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

endpackage

// File: rtl/relu_act.sv
// Combinational per-element activation: identity, ReLU or leaky ReLU (arithmetic shift).
module relu_act
  import relu_stream_bridge_pkg::*;
#(
  parameter int DATA_WIDTH  = 24,
  parameter int ACT_MODE    = 1,
  parameter int LEAKY_SHIFT = 3
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  output logic [DATA_WIDTH-1:0] y_o
);

  localparam act_mode_e MODE = act_mode_e'(ACT_MODE);

  logic                  neg;
  logic [DATA_WIDTH-1:0] shifted;

  assign neg     = x_i[DATA_WIDTH-1];
  // Shift rounds toward -inf, so small negatives saturate at -1 rather than 0.
  assign shifted = $signed(x_i) >>> LEAKY_SHIFT;

  always_comb begin
    y_o = x_i;
    case (MODE)
      ACT_RELU:  if (neg) y_o = '0;
      ACT_LEAKY: if (neg) y_o = shifted;
      default:   y_o = x_i;
    endcase
  end

endmodule

// File: rtl/relu_stream_bridge.sv
// Activation + ping-pong frame buffers + LANES-wide serializer with ready/valid on both sides.
// Optional statistics counters enabled with RELU_STREAM_BRIDGE_STATS_EN.
module relu_stream_bridge
  import relu_stream_bridge_pkg::*;
#(
  parameter  int DATA_WIDTH  = 24,
  parameter  int NUM_NODES   = 500,
  parameter  int LANES       = 1,
  parameter  int ACT_MODE    = 1,
  parameter  int LEAKY_SHIFT = 3,
  localparam int BEATS       = beats(NUM_NODES, LANES),
  localparam int IDX_W       = idx_width(BEATS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_valid,
  output logic                            i_ready,
  input  logic [NUM_NODES*DATA_WIDTH-1:0] din,
  output logic                            o_valid,
  input  logic                            o_ready,
  output logic [LANES*DATA_WIDTH-1:0]     o_data,
  output logic [IDX_W-1:0]                o_index,
  output logic                            o_last
`ifdef RELU_STREAM_BRIDGE_STATS_EN
  ,
  output logic [31:0]                     frames_out,
  output logic [15:0]                     frames_dropped
`endif
);

  localparam int FRAME_W = NUM_NODES * DATA_WIDTH;
  localparam int BEAT_W  = LANES * DATA_WIDTH;
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  logic [FRAME_W-1:0] act_frame;
  logic [FRAME_W-1:0] buf0_q, buf1_q;
  logic [FRAME_W-1:0] rd_frame;
  logic [BEAT_W-1:0]  beat_slices [BEATS];

  rd_state_e        state_q, state_d;
  logic [1:0]       full_q, full_d;
  logic             wr_sel_q, wr_sel_d;
  logic             rd_sel_q, rd_sel_d;
  logic [IDX_W-1:0] beat_q, beat_d;

  logic capture;
  logic beat_fire;
  logic frame_done;

  for (genvar n = 0; n < NUM_NODES; n++) begin : g_act
    relu_act #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACT_MODE   (ACT_MODE),
      .LEAKY_SHIFT(LEAKY_SHIFT)
    ) u_act (
      .x_i(din[n*DATA_WIDTH +: DATA_WIDTH]),
      .y_o(act_frame[n*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  // Only registered occupancy feeds i_ready, so a buffer freed this edge is not reusable until next cycle.
  assign i_ready    = !rst && !full_q[wr_sel_q];
  assign capture    = i_valid && i_ready;
  assign o_valid    = (state_q == STREAM);
  assign beat_fire  = o_valid && o_ready;
  assign frame_done = beat_fire && (beat_q == LAST_BEAT);

  always_comb begin
    full_d   = full_q;
    wr_sel_d = wr_sel_q;
    rd_sel_d = rd_sel_q;
    beat_d   = beat_q;
    if (capture) begin
      full_d[wr_sel_q] = 1'b1;
      wr_sel_d         = !wr_sel_q;
    end
    if (beat_fire) begin
      if (frame_done) begin
        beat_d           = '0;
        full_d[rd_sel_q] = 1'b0;
        rd_sel_d         = !rd_sel_q;
      end else begin
        beat_d = beat_q + 1'b1;
      end
    end
  end

  // Looking at next-cycle occupancy gives one-cycle capture latency and no bubble between frames.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (full_d[rd_sel_d]) state_d = STREAM;
      STREAM:  if (frame_done && !full_d[rd_sel_d]) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      full_q   <= '0;
      wr_sel_q <= 1'b0;
      rd_sel_q <= 1'b0;
      beat_q   <= '0;
    end else begin
      state_q  <= state_d;
      full_q   <= full_d;
      wr_sel_q <= wr_sel_d;
      rd_sel_q <= rd_sel_d;
      beat_q   <= beat_d;
    end
  end

  always_ff @(posedge clk) begin
    if (capture && !wr_sel_q) buf0_q <= act_frame;
    if (capture && wr_sel_q)  buf1_q <= act_frame;
  end

  assign rd_frame = rd_sel_q ? buf1_q : buf0_q;

  for (genvar b = 0; b < BEATS; b++) begin : g_beat
    assign beat_slices[b] = rd_frame[b*BEAT_W +: BEAT_W];
  end

  assign o_data  = o_valid ? beat_slices[beat_q] : '0;
  assign o_index = beat_q;
  assign o_last  = o_valid && (beat_q == LAST_BEAT);

`ifdef RELU_STREAM_BRIDGE_STATS_EN
  logic [31:0] frames_out_q;
  logic [15:0] frames_dropped_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      frames_out_q     <= '0;
      frames_dropped_q <= '0;
    end else begin
      if (frame_done) frames_out_q <= frames_out_q + 32'd1;
      if (i_valid && !i_ready && (frames_dropped_q != 16'hFFFF))
        frames_dropped_q <= frames_dropped_q + 16'd1;
    end
  end

  assign frames_out     = frames_out_q;
  assign frames_dropped = frames_dropped_q;
`endif

endmodule

// File: tb/tb_relu_stream_bridge.sv
// Directed self-checking bench for relu_stream_bridge (8 nodes, 2 lanes); ReLU and leaky instances.
module tb_relu_stream_bridge;

  localparam int DW = 24;
  localparam int NN = 8;
  localparam int LN = 2;
  localparam int NB = NN / LN;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             iValid;
  logic             iReady;
  logic [NN*DW-1:0] din;
  logic             oValid;
  logic             oReady;
  logic [LN*DW-1:0] oData;
  logic [1:0]       oIndex;
  logic             oLast;

  logic             lkValid;
  logic             lkIReady;
  logic [NN*DW-1:0] lkDin;
  logic             lkOValid;
  logic             lkReady;
  logic [LN*DW-1:0] lkOData;
  logic [1:0]       lkOIndex;
  logic             lkOLast;

`ifdef RELU_STREAM_BRIDGE_STATS_EN
  logic [31:0] framesOut, lkFramesOut;
  logic [15:0] framesDropped, lkFramesDropped;
`endif

  int compCount = 0;
  int failCount = 0;

  relu_stream_bridge #(
    .DATA_WIDTH(DW), .NUM_NODES(NN), .LANES(LN), .ACT_MODE(1), .LEAKY_SHIFT(3)
  ) dut (
    .clk(clk), .rst(rst), .i_valid(iValid), .i_ready(iReady), .din(din),
    .o_valid(oValid), .o_ready(oReady), .o_data(oData), .o_index(oIndex), .o_last(oLast)
`ifdef RELU_STREAM_BRIDGE_STATS_EN
    , .frames_out(framesOut), .frames_dropped(framesDropped)
`endif
  );

  relu_stream_bridge #(
    .DATA_WIDTH(DW), .NUM_NODES(NN), .LANES(LN), .ACT_MODE(2), .LEAKY_SHIFT(3)
  ) dutLeaky (
    .clk(clk), .rst(rst), .i_valid(lkValid), .i_ready(lkIReady), .din(lkDin),
    .o_valid(lkOValid), .o_ready(lkReady), .o_data(lkOData), .o_index(lkOIndex), .o_last(lkOLast)
`ifdef RELU_STREAM_BRIDGE_STATS_EN
    , .frames_out(lkFramesOut), .frames_dropped(lkFramesDropped)
`endif
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [NN*DW-1:0] packFrame(input int f[NN]);
    logic [NN*DW-1:0] p;
    int v;
    p = '0;
    for (int i = 0; i < NN; i++) begin
      v = f[i];
      p[i*DW +: DW] = v[DW-1:0];
    end
    return p;
  endfunction

  // mode 0: values already hand-activated; 1: ReLU; 2: leaky with shift 3
  function automatic int actModel(input int x, input int mode);
    if (mode == 1) return (x < 0) ? 0 : x;
    if (mode == 2) return (x < 0) ? (x >>> 3) : x;
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [NN*DW-1:0] d, input logic r);
    iValid = v;
    din    = d;
    oReady = r;
  endtask

  task automatic checkBeat(input string tag, input bit leaky, input int vals[NN], input int mode, input int b);
    logic [LN*DW-1:0] expData;
    int v;
    for (int k = 0; k < LN; k++) begin
      v = actModel(vals[b*LN+k], mode);
      expData[k*DW +: DW] = v[DW-1:0];
    end
    checkOutput($sformatf("%s_b%0d_valid", tag, b), leaky ? lkOValid : oValid, 1);
    checkOutput($sformatf("%s_b%0d_index", tag, b), leaky ? lkOIndex : oIndex, b);
    checkOutput($sformatf("%s_b%0d_data", tag, b), leaky ? lkOData : oData, expData);
    checkOutput($sformatf("%s_b%0d_last", tag, b), leaky ? lkOLast : oLast, (b == NB - 1));
  endtask

  task automatic expectStream(input string tag, input bit leaky, input int vals[NN], input int mode);
    for (int b = 0; b < NB; b++) begin
      checkBeat(tag, leaky, vals, mode, b);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int frameA[NN]   = '{-5, 3, 0, 7, -1, 2, -8, 4};
    int reluExpA[NN] = '{0, 3, 0, 7, 0, 2, 0, 4};
    int leakyIn[NN]  = '{-16, -1, 9, 0, -9, 100, -8, 7};
    int leakyExp[NN] = '{-2, -1, 9, 0, -2, 100, -1, 7};
    int frameB[NN]   = '{10, -20, 30, -40, 50, -60, 70, -80};
    int frameC[NN]   = '{-1, -2, -3, -4, 5, 6, 7, 8};
    int frameD[NN]   = '{1, 1, 1, 1, 1, 1, 1, 1};
    int frameE[NN]   = '{-100, 200, -300, 400, 500, -600, 700, -800};
    int expBeat;
    int cycles;

    rst = 1'b1;
    lkValid = 1'b0; lkDin = '0; lkReady = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    tick();
    checkOutput("rst_o_valid", oValid, 0);
    checkOutput("rst_o_last", oLast, 0);
    checkOutput("rst_o_index", oIndex, 0);
    checkOutput("rst_o_data", oData, 0);
    checkOutput("rst_i_ready", iReady, 0);
    rst = 1'b0;
    #1;
    checkOutput("post_rst_i_ready", iReady, 1);

    $display("[TB] ReLU frame, ready held high");
    applyStimulus(1'b1, packFrame(frameA), 1'b1);
    checkOutput("t1_idle_valid", oValid, 0);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    expectStream("t1", 1'b0, reluExpA, 0);
    checkOutput("t1_end_valid", oValid, 0);

    $display("[TB] leaky ReLU frame");
    lkValid = 1'b1;
    lkDin   = packFrame(leakyIn);
    tick();
    lkValid = 1'b0;
    expectStream("t2", 1'b1, leakyExp, 0);
    checkOutput("t2_end_valid", lkOValid, 0);

    $display("[TB] two frames under backpressure, third dropped");
    applyStimulus(1'b1, packFrame(frameB), 1'b0);
    checkOutput("t3_ready_B", iReady, 1);
    tick();
    applyStimulus(1'b1, packFrame(frameC), 1'b0);
    checkOutput("t3_ready_C", iReady, 1);
    tick();
    checkOutput("t3_full_ready", iReady, 0);
    applyStimulus(1'b1, packFrame(frameD), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    checkBeat("t3_stall0", 1'b0, frameB, 1, 0);
    tick();
    checkBeat("t3_stall1", 1'b0, frameB, 1, 0);
`ifdef RELU_STREAM_BRIDGE_STATS_EN
    checkOutput("t3_frames_dropped", framesDropped, 1);
    checkOutput("t3_frames_out_pre", framesOut, 1);
`endif
    oReady = 1'b1;
    expectStream("t3_B", 1'b0, frameB, 1);
    expectStream("t3_C", 1'b0, frameC, 1);
    checkOutput("t3_end_valid", oValid, 0);
`ifdef RELU_STREAM_BRIDGE_STATS_EN
    checkOutput("t3_frames_out", framesOut, 3);
`endif

    $display("[TB] random backpressure");
    applyStimulus(1'b1, packFrame(frameE), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0);
    expBeat = 0;
    cycles  = 0;
    while (expBeat < NB && cycles < 60) begin
      checkBeat("t4", 1'b0, frameE, 1, expBeat);
      oReady = 1'($urandom_range(0, 1));
      tick();
      if (oReady) expBeat++;
      cycles++;
    end
    checkOutput("t4_all_beats", expBeat, NB);
    checkOutput("t4_end_valid", oValid, 0);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, packFrame(frameA), 1'b0);
    tick();
    applyStimulus(1'b1, packFrame(frameB), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    tick();
    checkBeat("t5_pre", 1'b0, frameA, 1, 2);
    rst = 1'b1;
    tick();
    checkOutput("t5_rst_valid", oValid, 0);
    checkOutput("t5_rst_data", oData, 0);
    checkOutput("t5_rst_last", oLast, 0);
    checkOutput("t5_rst_i_ready", iReady, 0);
    rst = 1'b0;
    #1;
    checkOutput("t5_i_ready", iReady, 1);
`ifdef RELU_STREAM_BRIDGE_STATS_EN
    checkOutput("t5_frames_out_clr", framesOut, 0);
    checkOutput("t5_frames_dropped_clr", framesDropped, 0);
`endif
    applyStimulus(1'b1, packFrame(frameC), 1'b1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    expectStream("t5_C", 1'b0, frameC, 1);
    checkOutput("t5_end_valid", oValid, 0);

    $display("[TB] offer collides with last beat while both buffers full");
    applyStimulus(1'b1, packFrame(frameA), 1'b0);
    tick();
    applyStimulus(1'b1, packFrame(frameE), 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    for (int b = 0; b < NB - 1; b++) begin
      checkBeat("t6_X", 1'b0, frameA, 1, b);
      tick();
    end
    checkBeat("t6_X", 1'b0, frameA, 1, NB - 1);
    checkOutput("t6_full_ready", iReady, 0);
    applyStimulus(1'b1, packFrame(leakyIn), 1'b1);
    tick();
    checkBeat("t6_Y", 1'b0, frameE, 1, 0);
    checkOutput("t6_freed_ready", iReady, 1);
    tick();
    applyStimulus(1'b0, '0, 1'b1);
    for (int b = 1; b < NB; b++) begin
      checkBeat("t6_Y", 1'b0, frameE, 1, b);
      tick();
    end
    expectStream("t6_Z", 1'b0, leakyIn, 1);
    checkOutput("t6_end_valid", oValid, 0);
`ifdef RELU_STREAM_BRIDGE_STATS_EN
    checkOutput("t6_frames_dropped", framesDropped, 1);
    checkOutput("t6_frames_out", framesOut, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, failCount);
    $finish;
  end

endmodule
